led_scanner_pwm: RTL and testbench

Parametrised PWM LED scanner for the board top level. It drives N_CH LEDs with a moving brightness peak that crossfades between neighbouring channels. Runtime inputs select the mode (bounce, circular wrap, all-channel breathe, off), set the step rate, and pause motion. It replaces the fixed 8-LED, 24-bit bounce-only chaser with one reusable block.

---
 rtl/led_pkg.sv | 22 ++
 rtl/led_scanner_pwm_if.sv | 15 +
 rtl/led_pwm_chan.sv | 23 ++
 rtl/led_scanner_pwm.sv | 124 ++++++++++++
 tb/tb_led_scanner_pwm.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared encodings for the LED scanner: mode selector, sweep direction and
// the channel-index width helper.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE  = 2'd0,
        MODE_WRAP    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_OFF     = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    // Channel index width, never below one bit.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_scanner_pwm_if.sv
// Control and LED bundle of the scanner.
// The board side drives hold/mode/div. The scanner drives led/step.
interface led_scanner_pwm_if #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned DIV_W = 16
);
    logic             hold;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [N_CH-1:0]  led;
    logic             step;

    modport master (output hold, mode, div, input  led, step);
    modport slave  (input  hold, mode, div, output led, step);
endinterface

// File: rtl/led_pwm_chan.sv
// One LED channel: registers its selected brightness, then compares it
// against the shared PWM counter.
module led_pwm_chan #(
    parameter int unsigned PWM_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] bright_in,
    input  logic [PWM_W-1:0] pwm_ctr,
    output logic             led
);
    logic [PWM_W-1:0] bright;

    always_ff @(posedge clk) begin
        if (rst) begin
            bright <= '0;
            led    <= 1'b0;
        end else begin
            bright <= bright_in;
            led    <= (pwm_ctr < bright);
        end
    end
endmodule

// File: rtl/led_scanner_pwm.sv
// PWM LED scanner: a moving brightness peak that crossfades between channels,
// with bounce, wrap, breathe and off modes.
module led_scanner_pwm
    import led_pkg::*;
#(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned PWM_W = 10,
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    led_scanner_pwm_if.slave bus
);
    localparam int unsigned      CH_W     = ch_w(N_CH);
    localparam int unsigned      POS_W    = CH_W + PWM_W;
    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(N_CH * (2 ** PWM_W) - 1);
    localparam logic [POS_W-1:0] BRTH_MAX = POS_W'((2 ** PWM_W) - 1);
    localparam logic [PWM_W-1:0] MAXB     = '1;

    logic [POS_W-1:0] pos;
    dir_t             dir;
    logic [DIV_W-1:0] presc;
    logic [PWM_W-1:0] pwm_ctr;
    mode_t            mode_q;
    logic             step_q;

    mode_t            mode_in;
    logic             mode_chg;
    logic             se;
    logic [POS_W-1:0] limit;
    logic [PWM_W-1:0] frac;
    int unsigned      seg_u;
    int unsigned      nxt_ch;
    int unsigned      prv_ch;
    logic [N_CH-1:0]  led_bits;

    assign mode_in  = mode_t'(bus.mode);
    assign mode_chg = (mode_in != mode_q);
    assign se       = !bus.hold && (presc == bus.div) && (mode_q != MODE_OFF);
    assign limit    = (mode_q == MODE_BREATHE) ? BRTH_MAX : POS_MAX;
    assign seg_u    = 32'(pos[POS_W-1:PWM_W]);
    assign frac     = pos[PWM_W-1:0];

    // Prescaler, mode tracking and the position/direction sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos     <= '0;
            dir     <= DIR_UP;
            presc   <= '0;
            pwm_ctr <= '0;
            mode_q  <= MODE_BOUNCE;
            step_q  <= 1'b0;
        end else begin
            pwm_ctr <= pwm_ctr + PWM_W'(1);
            step_q  <= 1'b0;
            if (mode_chg) begin
                mode_q <= mode_in;
                pos    <= '0;
                dir    <= DIR_UP;
                presc  <= '0;
            end else if (se) begin
                presc  <= '0;
                step_q <= 1'b1;
                if (mode_q == MODE_WRAP) begin
                    pos <= (pos == POS_MAX) ? '0 : pos + POS_W'(1);
                    dir <= DIR_UP;
                end else if (dir == DIR_UP) begin
                    if (pos == limit) begin
                        dir <= DIR_DOWN;
                        pos <= limit - POS_W'(1);
                    end else begin
                        pos <= pos + POS_W'(1);
                    end
                end else begin
                    if (pos == '0) begin
                        dir <= DIR_UP;
                        pos <= POS_W'(1);
                    end else begin
                        pos <= pos - POS_W'(1);
                    end
                end
            end else if (!bus.hold) begin
                presc <= presc + DIV_W'(1);
            end
        end
    end

    // Neighbour channels. N_CH marks a neighbour that does not exist.
    always_comb begin
        nxt_ch = seg_u + 32'd1;
        prv_ch = (seg_u == 32'd0) ? N_CH : seg_u - 32'd1;
        if (mode_q == MODE_WRAP) begin
            if (nxt_ch == N_CH) nxt_ch = 32'd0;
            if (seg_u == 32'd0) prv_ch = N_CH - 32'd1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        localparam int unsigned CH = g;
        logic [PWM_W-1:0] b_sel;

        always_comb begin
            b_sel = '0;
            if (mode_q == MODE_BREATHE) begin
                b_sel = frac;
            end else if (mode_q != MODE_OFF) begin
                if (CH == seg_u)       b_sel = MAXB;
                else if (CH == nxt_ch) b_sel = frac;
                else if (CH == prv_ch) b_sel = MAXB - frac;
            end
        end

        led_pwm_chan #(.PWM_W(PWM_W)) u_chan (
            .clk       (clk),
            .rst       (rst),
            .bright_in (b_sel),
            .pwm_ctr   (pwm_ctr),
            .led       (led_bits[g])
        );
    end

    assign bus.led  = led_bits;
    assign bus.step = step_q;
endmodule

// File: tb/tb_led_scanner_pwm.sv
// Bench for led_scanner_pwm: a brightness table measured as PWM duty,
// directed corner sequences, and random traffic against a reference model.
module tb_led_scanner_pwm;
    import led_pkg::*;

    localparam int N    = 4;
    localparam int PW   = 4;
    localparam int DW   = 16;
    localparam int NPWM = 16;
    localparam int MAXB = 15;
    localparam int PMAX = 63;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    led_scanner_pwm_if #(.N_CH(N), .DIV_W(DW)) bus ();

    led_scanner_pwm #(.N_CH(N), .PWM_W(PW), .DIV_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int         m_pos, m_dir, m_presc, m_pwm, m_mode;
    int         m_bright[N];
    logic [N-1:0] m_led;
    logic       m_step;

    typedef struct {
        string       name;
        int          md;
        int          steps;
        logic [15:0] exp;   // expected brightness, one nibble per channel, ch3..ch0
    } vec_t;
    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Brightness from channel distance to the peak segment.
    function automatic int rule_bright(input int pos, input int md, input int ch);
        int seg  = pos / NPWM;
        int frac = pos % NPWM;
        int d;
        if (md == 3) return 0;
        if (md == 2) return frac;
        if (md == 1) d = (ch - seg + N) % N;
        else         d = ch - seg;
        if (d == 0) return MAXB;
        if (d == 1) return frac;
        if (d == -1 || (md == 1 && d == N - 1)) return MAXB - frac;
        return 0;
    endfunction

    task automatic model_step();
        int           nb[N];
        logic [N-1:0] nl;
        int           lim;
        bit           se;
        if (rst) begin
            m_pos = 0; m_dir = 1; m_presc = 0; m_pwm = 0; m_mode = 0;
            for (int i = 0; i < N; i++) m_bright[i] = 0;
            m_led = '0; m_step = 1'b0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            nl[i] = (m_pwm < m_bright[i]);
            nb[i] = rule_bright(m_pos, m_mode, i);
        end
        m_pwm  = (m_pwm + 1) % NPWM;
        m_step = 1'b0;
        se = !bus.hold && (m_presc == int'(bus.div)) && (m_mode != 3);
        if (int'(bus.mode) != m_mode) begin
            m_mode = int'(bus.mode); m_pos = 0; m_dir = 1; m_presc = 0;
        end else if (se) begin
            m_presc = 0;
            m_step  = 1'b1;
            lim = (m_mode == 2) ? MAXB : PMAX;
            if (m_mode == 1)               m_pos = (m_pos == PMAX) ? 0 : m_pos + 1;
            else if (m_dir == 1) begin
                if (m_pos == lim) begin m_dir = 0; m_pos = lim - 1; end
                else m_pos = m_pos + 1;
            end else begin
                if (m_pos == 0) begin m_dir = 1; m_pos = 1; end
                else m_pos = m_pos - 1;
            end
        end else if (!bus.hold) begin
            m_presc = (m_presc + 1) % (1 << DW);
        end
        for (int i = 0; i < N; i++) m_bright[i] = nb[i];
        m_led = nl;
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("led_vs_model", 32'(bus.led), 32'(m_led));
        check("step_vs_model", 32'(bus.step), 32'(m_step));
    endtask

    // Reset, enter mode md at pos 0, then take the given number of div=0 steps.
    task automatic reach(input int md, input int steps);
        rst = 1'b1; bus.hold = 1'b0; bus.mode = 2'd0; bus.div = '0;
        run_cycle();
        rst = 1'b0;
        if (md != 0) begin
            bus.mode = 2'(md);
            run_cycle();
        end
        repeat (steps) run_cycle();
    endtask

    // With position frozen, high count over one PWM period equals brightness.
    task automatic duty_check(input string name, input logic [15:0] exp);
        int cnt[N];
        repeat (2) run_cycle();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        repeat (NPWM) begin
            run_cycle();
            for (int i = 0; i < N; i++) cnt[i] += int'(bus.led[i]);
        end
        for (int i = 0; i < N; i++)
            check($sformatf("%s_ch%0d", name, i), 32'(cnt[i]), 32'(exp[i*4 +: 4]));
    endtask

    task automatic wait_step(output int n);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            run_cycle();
            n++;
            if (bus.step === 1'b1) return;
        end
        n = -1;
    endtask

    initial begin
        int n;
        int nd;
        vecs[0]  = '{"bounce_p0",    0,  0, 16'h000F};
        vecs[1]  = '{"bounce_p17",   0, 17, 16'h01FE};
        vecs[2]  = '{"bounce_p20",   0, 20, 16'h04FB};
        vecs[3]  = '{"bounce_p52",   0, 52, 16'hFB00};
        vecs[4]  = '{"bounce_p63",   0, 63, 16'hF000};
        vecs[5]  = '{"bounce_turn",  0, 64, 16'hF100};
        vecs[6]  = '{"wrap_p5",      1,  5, 16'hA05F};
        vecs[7]  = '{"wrap_p60",     1, 60, 16'hF30C};
        vecs[8]  = '{"wrap_to0",     1, 64, 16'hF00F};
        vecs[9]  = '{"breathe_p7",   2,  7, 16'h7777};
        vecs[10] = '{"breathe_p15",  2, 15, 16'hFFFF};
        vecs[11] = '{"breathe_turn", 2, 16, 16'hEEEE};
        vecs[12] = '{"breathe_back0",2, 30, 16'h0000};

        rst = 1'b1; bus.hold = 1'b1; bus.mode = 2'd0; bus.div = '0;
        run_cycle();
        check("reset_led", 32'(bus.led), 32'd0);
        check("reset_step", 32'(bus.step), 32'd0);

        foreach (vecs[v]) begin
            reach(vecs[v].md, vecs[v].steps);
            bus.hold = 1'b1;
            duty_check(vecs[v].name, vecs[v].exp);
        end

        // Step period and hold freezing the prescaler mid-count.
        rst = 1'b1; bus.hold = 1'b0; bus.mode = 2'd0; bus.div = DW'(4);
        run_cycle();
        rst = 1'b0;
        wait_step(n);
        check("first_step_div4", 32'(n), 32'd5);
        wait_step(n);
        check("period_div4", 32'(n), 32'd5);
        repeat (2) run_cycle();
        bus.hold = 1'b1;
        repeat (7) run_cycle();
        bus.hold = 1'b0;
        wait_step(n);
        check("period_with_hold", 32'(n < 0 ? n : n + 9), 32'd12);

        // BOUNCE -> OFF at pos 40, then back to WRAP from pos 0.
        reach(0, 40);
        bus.mode = 2'd3;
        run_cycle();
        repeat (2) run_cycle();
        for (int k = 0; k < 20; k++) begin
            run_cycle();
            check("off_led", 32'(bus.led), 32'd0);
            check("off_step", 32'(bus.step), 32'd0);
        end
        bus.mode = 2'd1;
        run_cycle();
        repeat (5) run_cycle();
        bus.hold = 1'b1;
        duty_check("wrap_restart", 16'hA05F);

        // Reset mid-sweep at pos 30 on the way down, with hold asserted.
        reach(0, 96);
        rst = 1'b1; bus.hold = 1'b1;
        run_cycle();
        check("midrst_led", 32'(bus.led), 32'd0);
        check("midrst_step", 32'(bus.step), 32'd0);
        rst = 1'b0; bus.hold = 1'b0;
        repeat (3) run_cycle();
        bus.hold = 1'b1;
        duty_check("after_rst", 16'h003F);

        // Random traffic against the model.
        rst = 1'b0; bus.hold = 1'b0; bus.div = '0;
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 149) == 0) bus.mode = 2'($urandom_range(0, 3));
            bus.hold = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) begin
                nd = int'($urandom_range(0, 5));
                if (nd >= m_presc) bus.div = DW'(nd);
            end
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
